// File: rtl/dffram_mbist.sv
// dffram_mbist
// March C- built-in self-test controller for a single-port DFFRAM macro.
// It passes the system port through to the RAM while idle. On start it takes
// over the port and runs the six March C- elements, checking every read one
// cycle after it is issued. It keeps first-failure diagnostics until the next start.

module dffram_mbist #(
    parameter int unsigned   AW           = 7,
    parameter int unsigned   DW           = 32,
    parameter logic [DW-1:0] PATTERN      = '0,
    parameter bit            STOP_ON_FAIL = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AW-1:0]     fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DW-1:0]     fail_data,

    input  logic [DW/8-1:0]   sys_WE0,
    input  logic              sys_EN0,
    input  logic [AW-1:0]     sys_A0,
    input  logic [DW-1:0]     sys_Di0,
    output logic [DW-1:0]     sys_Do0,

    output logic [DW/8-1:0]   WE0,
    output logic              EN0,
    output logic [AW-1:0]     A0,
    output logic [DW-1:0]     Di0,
    input  logic [DW-1:0]     Do0
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [2:0]    ELEM_LAST = 3'd5;

    state_t state_q, state_d;

    // Sequencing: address within the element, element index 0..5, and which
    // half of a read/write pair is being issued.
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      elem_q, elem_d;
    logic            phase_q, phase_d;

    // Read-check pipeline: describes the read issued in the previous cycle.
    logic            pipeValid_q, pipeValid_d;
    logic [DW-1:0]   pipeExp_q, pipeExp_d;
    logic [AW-1:0]   pipeAddr_q, pipeAddr_d;
    logic [2:0]      pipeElem_q, pipeElem_d;

    // Result and first-failure diagnostics.
    logic            pass_q, pass_d;
    logic [AW-1:0]   failAddr_q, failAddr_d;
    logic [2:0]      failElem_q, failElem_d;
    logic [DW-1:0]   failData_q, failData_d;

    // Decode of the operation selected by the current counters.
    logic            isPair;
    logic            opWrite;
    logic            descending;
    logic            addrEnd;
    logic            opLast;
    logic            lastOp;
    logic [DW-1:0]   wrData;
    logic [DW-1:0]   rdExp;
    logic            mismatch;

    // Port values the BIST drives while it owns the RAM.
    logic            bistOwns;
    logic            bistEn;
    logic [DW/8-1:0] bistWe;
    logic [AW-1:0]   bistA;
    logic [DW-1:0]   bistDi;

    // Decode the current March op.
    // E1..E4 are read/write pairs, E3/E4 walk downwards, and the odd
    // elements write the inverted background.
    always_comb begin
        isPair     = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        opWrite    = (elem_q == 3'd0) || (isPair && phase_q);
        descending = (elem_q == 3'd3) || (elem_q == 3'd4);
        addrEnd    = descending ? (addr_q == '0) : (addr_q == ADDR_MAX);
        opLast     = isPair ? phase_q : 1'b1;
        lastOp     = (elem_q == ELEM_LAST) && addrEnd;
        wrData     = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~PATTERN : PATTERN;
        rdExp      = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~PATTERN : PATTERN;
        mismatch   = pipeValid_q && (Do0 != pipeExp_q);
    end

    // Next FSM state.
    // A mismatch can end the run early, and DRAIN leaves one cycle for the
    // final read to be checked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (STOP_ON_FAIL && mismatch) begin
                    state_d = S_DONE;
                end else if (lastOp) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Advance the address, element and pair-phase counters.
    // The address wraps only at element boundaries. The next element starts
    // at N-1 when it walks downwards.
    always_comb begin
        addr_d  = addr_q;
        elem_d  = elem_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    elem_d  = 3'd0;
                    phase_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!opLast) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addrEnd) begin
                        if (elem_q == ELEM_LAST) begin
                            elem_d = 3'd0;
                            addr_d = '0;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
                        end
                    end else begin
                        addr_d = descending ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                    end
                end
            end
            default: ;
        endcase
    end

    // Record what the read issued this cycle should return next cycle.
    always_comb begin
        pipeValid_d = (state_q == S_RUN) && !opWrite;
        pipeExp_d   = rdExp;
        pipeAddr_d  = addr_q;
        pipeElem_d  = elem_q;
    end

    // Update the pass flag and diagnostics.
    // A start clears them. Only the first mismatch is captured, because
    // pass is still 1 at that point.
    always_comb begin
        pass_d     = pass_q;
        failAddr_d = failAddr_q;
        failElem_d = failElem_q;
        failData_d = failData_q;
        if ((state_q == S_IDLE) && start) begin
            pass_d     = 1'b1;
            failAddr_d = '0;
            failElem_d = 3'd0;
            failData_d = '0;
        end else if (mismatch && pass_q) begin
            pass_d     = 1'b0;
            failAddr_d = pipeAddr_q;
            failElem_d = pipeElem_q;
            failData_d = Do0;
        end
    end

    // Drive the RAM port.
    // The BIST keeps ownership through DRAIN and DONE with the RAM disabled,
    // so system traffic never slips in before the test has fully wound down.
    always_comb begin
        bistOwns = (state_q != S_IDLE);
        bistEn   = (state_q == S_RUN);
        bistWe   = ((state_q == S_RUN) && opWrite) ? '1 : '0;
        bistA    = addr_q;
        bistDi   = ((state_q == S_RUN) && opWrite) ? wrData : '0;
        if (bistOwns) begin
            WE0 = bistWe;
            EN0 = bistEn;
            A0  = bistA;
            Di0 = bistDi;
        end else begin
            WE0 = sys_WE0;
            EN0 = sys_EN0;
            A0  = sys_A0;
            Di0 = sys_Di0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencing counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q  <= '0;
            elem_q  <= 3'd0;
            phase_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
        end
    end

    // Read-check pipeline registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pipeValid_q <= 1'b0;
            pipeExp_q   <= '0;
            pipeAddr_q  <= '0;
            pipeElem_q  <= 3'd0;
        end else begin
            pipeValid_q <= pipeValid_d;
            pipeExp_q   <= pipeExp_d;
            pipeAddr_q  <= pipeAddr_d;
            pipeElem_q  <= pipeElem_d;
        end
    end

    // Result and diagnostic registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pass_q     <= 1'b0;
            failAddr_q <= '0;
            failElem_q <= 3'd0;
            failData_q <= '0;
        end else begin
            pass_q     <= pass_d;
            failAddr_q <= failAddr_d;
            failElem_q <= failElem_d;
            failData_q <= failData_d;
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign fail_addr = failAddr_q;
    assign fail_elem = failElem_q;
    assign fail_data = failData_q;
    assign sys_Do0   = Do0;

endmodule

// File: tb/tb_dffram_mbist.sv
// tb_dffram_mbist
// Directed bench for dffram_mbist. There are two instances, one running to
// completion and one stopping at the first failure. Each has its own
// behavioural DFFRAM with an optional stuck-at-1 cell.

module tb_dffram_mbist;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int WS = DW / 8;
    localparam int N  = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          startA = 1'b0;
    logic          startB = 1'b0;

    logic [WS-1:0] sys_WE0 = '0;
    logic          sys_EN0 = 1'b0;
    logic [AW-1:0] sys_A0  = '0;
    logic [DW-1:0] sys_Di0 = '0;

    logic          busyA, doneA, passA, enA;
    logic [AW-1:0] failAddrA, addrA;
    logic [2:0]    failElemA;
    logic [DW-1:0] failDataA, sysDoA, diA;
    logic [WS-1:0] weA;
    logic [DW-1:0] doA = '0;

    logic          busyB, doneB, passB, enB;
    logic [AW-1:0] failAddrB, addrB;
    logic [2:0]    failElemB;
    logic [DW-1:0] failDataB, sysDoB, diB;
    logic [WS-1:0] weB;
    logic [DW-1:0] doB = '0;

    logic [DW-1:0] memA [N];
    logic [DW-1:0] memB [N];
    logic          faultEn = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    int doneCycle, firstBusy, lastBusy, doneCount, readCount, leakCount;

    dffram_mbist #(.AW(AW), .DW(DW), .PATTERN(32'h0000_0000), .STOP_ON_FAIL(1'b0)) dutA (
        .CLK(CLK), .RST(RST), .start(startA),
        .busy(busyA), .done(doneA), .pass(passA),
        .fail_addr(failAddrA), .fail_elem(failElemA), .fail_data(failDataA),
        .sys_WE0(sys_WE0), .sys_EN0(sys_EN0), .sys_A0(sys_A0), .sys_Di0(sys_Di0),
        .sys_Do0(sysDoA),
        .WE0(weA), .EN0(enA), .A0(addrA), .Di0(diA), .Do0(doA)
    );

    dffram_mbist #(.AW(AW), .DW(DW), .PATTERN(32'h0000_0000), .STOP_ON_FAIL(1'b1)) dutB (
        .CLK(CLK), .RST(RST), .start(startB),
        .busy(busyB), .done(doneB), .pass(passB),
        .fail_addr(failAddrB), .fail_elem(failElemB), .fail_data(failDataB),
        .sys_WE0(sys_WE0), .sys_EN0(sys_EN0), .sys_A0(sys_A0), .sys_Di0(sys_Di0),
        .sys_Do0(sysDoB),
        .WE0(weB), .EN0(enB), .A0(addrB), .Di0(diB), .Do0(doB)
    );

    always #5 CLK = ~CLK;

    // Stuck-at-1 on bit 5 of address 0x2A, visible on every read of that cell.
    function automatic logic [DW-1:0] faultMask(input logic [AW-1:0] a);
        return (faultEn && (a == 7'h2A)) ? 32'h0000_0020 : 32'h0000_0000;
    endfunction

    // Behavioural DFFRAM for instance A: byte-write enables, one-cycle read.
    always @(posedge CLK) begin
        if (enA) begin
            for (int b = 0; b < WS; b++) begin
                if (weA[b]) memA[addrA][8*b +: 8] <= diA[8*b +: 8];
            end
            doA <= memA[addrA] | faultMask(addrA);
        end
    end

    // Behavioural DFFRAM for instance B.
    always @(posedge CLK) begin
        if (enB) begin
            for (int b = 0; b < WS; b++) begin
                if (weB[b]) memB[addrB][8*b +: 8] <= diB[8*b +: 8];
            end
            doB <= memB[addrB] | faultMask(addrB);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic sysWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        sys_EN0 = 1'b1; sys_WE0 = '1; sys_A0 = a; sys_Di0 = d;
        @(negedge CLK);
        sys_EN0 = 1'b0; sys_WE0 = '0;
    endtask

    task automatic sysRead(input logic [AW-1:0] a);
        @(negedge CLK);
        sys_EN0 = 1'b1; sys_WE0 = '0; sys_A0 = a;
        @(negedge CLK);
        sys_EN0 = 1'b0;
    endtask

    // Pulse start, then watch one run cycle by cycle. Cycle 1 is the cycle
    // right after the edge that samples start.
    task automatic applyStimulus(input bit useB, input int restartAt, input bit driveSys);
        logic          b, d, en;
        logic [WS-1:0] we;
        logic [DW-1:0] di;
        doneCycle = 0; firstBusy = 0; lastBusy = 0;
        doneCount = 0; readCount = 0; leakCount = 0;
        @(negedge CLK);
        if (useB) startB = 1'b1; else startA = 1'b1;
        @(posedge CLK);
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge CLK);
            startA = 1'b0;
            startB = 1'b0;
            if (cyc == restartAt) begin
                if (useB) startB = 1'b1; else startA = 1'b1;
            end
            if (driveSys) begin
                sys_EN0 = (cyc < 1200);
                sys_WE0 = (cyc < 1200) ? 4'hF : 4'h0;
                sys_A0  = 7'h10;
                sys_Di0 = 32'h1234_5678;
            end
            b  = useB ? busyB : busyA;
            d  = useB ? doneB : doneA;
            en = useB ? enB : enA;
            we = useB ? weB : weA;
            di = useB ? diB : diA;
            if (b) begin
                if (firstBusy == 0) firstBusy = cyc;
                lastBusy = cyc;
                if (en && (we == '0)) readCount++;
                if (en && (we != '0) && (di == 32'h1234_5678)) leakCount++;
            end
            if (d) begin
                doneCount++;
                if (doneCycle == 0) doneCycle = cyc;
            end
            if ((doneCycle != 0) && (cyc >= doneCycle + 3)) break;
        end
        sys_EN0 = 1'b0; sys_WE0 = '0;
    endtask

    initial begin
        int activity;

        // Reset values and idle pass-through.
        sys_A0 = 7'h21;
        repeat (3) @(negedge CLK);
        checkOutput("reset_busy", busyA, 0);
        checkOutput("reset_done", doneA, 0);
        checkOutput("reset_pass", passA, 0);
        checkOutput("reset_fail_addr", failAddrA, 0);
        checkOutput("reset_fail_elem", failElemA, 0);
        checkOutput("reset_fail_data", failDataA, 0);
        checkOutput("reset_mirror_a0", addrA, 7'h21);
        RST = 1'b0;

        // Idle bypass write then read-back on both instances.
        sysWrite(7'h10, 32'hDEAD_BEEF);
        sysRead(7'h10);
        checkOutput("bypass_readA", sysDoA, 32'hDEAD_BEEF);
        checkOutput("bypass_readB", sysDoB, 32'hDEAD_BEEF);

        // Fault-free full run.
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("clean_done_cycle", doneCycle, 1282);
        checkOutput("clean_first_busy", firstBusy, 1);
        checkOutput("clean_last_busy", lastBusy, 1281);
        checkOutput("clean_done_pulses", doneCount, 1);
        checkOutput("clean_reads", readCount, 640);
        checkOutput("clean_pass", passA, 1);
        checkOutput("clean_fail_addr", failAddrA, 0);
        checkOutput("clean_fail_elem", failElemA, 0);
        sysRead(7'h10);
        checkOutput("clean_final_content", sysDoA, 32'h0000_0000);

        // Stuck-at-1, run to completion.
        faultEn = 1'b1;
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("sa1_done_cycle", doneCycle, 1282);
        checkOutput("sa1_pass", passA, 0);
        checkOutput("sa1_fail_elem", failElemA, 1);
        checkOutput("sa1_fail_addr", failAddrA, 7'h2A);
        checkOutput("sa1_fail_data", failDataA, 32'h0000_0020);

        // Same fault, stop at first failure.
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("stop_done_cycle", doneCycle, 215);
        checkOutput("stop_last_busy", lastBusy, 214);
        checkOutput("stop_pass", passB, 0);
        checkOutput("stop_fail_elem", failElemB, 1);
        checkOutput("stop_fail_addr", failAddrB, 7'h2A);
        checkOutput("stop_fail_data", failDataB, 32'h0000_0020);
        faultEn = 1'b0;

        // Restart attempt and system writes while busy.
        applyStimulus(1'b0, 500, 1'b1);
        checkOutput("restart_done_cycle", doneCycle, 1282);
        checkOutput("restart_done_pulses", doneCount, 1);
        checkOutput("restart_sys_leak", leakCount, 0);
        checkOutput("restart_pass", passA, 1);

        // Reset in cycle 700 of a run.
        @(negedge CLK);
        startA = 1'b1;
        @(posedge CLK);
        for (int cyc = 1; cyc < 700; cyc++) begin
            @(negedge CLK);
            startA = 1'b0;
        end
        checkOutput("midrun_busy", busyA, 1);
        checkOutput("midrun_pass", passA, 1);
        sys_A0 = 7'h55; sys_Di0 = 32'hCAFE_F00D; sys_WE0 = 4'h3; sys_EN0 = 1'b0;
        RST = 1'b1;
        #1;
        checkOutput("abort_busy", busyA, 0);
        checkOutput("abort_done", doneA, 0);
        checkOutput("abort_pass", passA, 0);
        checkOutput("abort_mirror_a0", addrA, 7'h55);
        checkOutput("abort_mirror_di0", diA, 32'hCAFE_F00D);
        checkOutput("abort_mirror_we0", weA, 4'h3);
        @(negedge CLK);
        checkOutput("abort_mirror_en0", enA, 0);
        RST = 1'b0;
        activity = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge CLK);
            if (busyA || enA) activity++;
        end
        checkOutput("post_reset_quiet", activity, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
